// File: rtl/pe_pool_2x2_if.sv
// Port bundle for the 2x2 max-pool stage: control/config, sample stream in,
// pooled stream and status out.
interface pe_pool_2x2_if #(
  parameter int OP_WIDTH      = 16,
  parameter int ADDR_WIDTH    = 8,
  parameter int ROW_CNT_WIDTH = 10
);
  logic                     start;
  logic                     cfg_pool_enable;
  logic [ADDR_WIDTH:0]      cfg_row_width;
  logic [ROW_CNT_WIDTH-1:0] cfg_num_rows;
  logic                     in_valid;
  logic [OP_WIDTH-1:0]      in_data;
  logic                     out_valid;
  logic [OP_WIDTH-1:0]      out_data;
  logic                     out_last;
  logic                     busy;
  logic                     done;
  logic                     cfg_error;

  modport master (
    output start, cfg_pool_enable, cfg_row_width, cfg_num_rows, in_valid, in_data,
    input  out_valid, out_data, out_last, busy, done, cfg_error
  );

  modport slave (
    input  start, cfg_pool_enable, cfg_row_width, cfg_num_rows, in_valid, in_data,
    output out_valid, out_data, out_last, busy, done, cfg_error
  );
endinterface

// File: rtl/pe_pool_2x2.sv
// Streaming 2x2 / stride-2 signed max-pool (or bypass) over a row-major tile.
// Even-row pair maxima wait in a half-row line buffer for the odd row.
module pe_pool_2x2 #(
  parameter int OP_WIDTH      = 16,
  parameter int ADDR_WIDTH    = 8,
  parameter int ROW_CNT_WIDTH = 10
) (
  input  logic          clk,
  input  logic          reset,
  pe_pool_2x2_if.slave  bus
);
  localparam int LBUF_DEPTH = 1 << (ADDR_WIDTH - 1);
  localparam logic [ADDR_WIDTH:0] W_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t                         r_state, w_state_next;
  logic                           r_pool;
  logic [ADDR_WIDTH:0]            r_width, r_col;
  logic [ROW_CNT_WIDTH-1:0]       r_rows, r_row;
  logic signed [OP_WIDTH-1:0]     r_hold, r_lbuf_q, r_out_data;
  logic                           r_out_valid, r_out_last, r_done, r_cfg_error;
  logic signed [OP_WIDTH-1:0]     r_lbuf [LBUF_DEPTH];

  logic                           w_pool_cfg_ok, w_byp_cfg_ok, w_cfg_ok;
  logic                           w_accept, w_last_col, w_last_row, w_frame_end;
  logic signed [OP_WIDTH-1:0]     w_in_data, w_pair_max, w_emit_data;
  logic                           w_emit, w_lbuf_we, w_lbuf_re;
  logic [ADDR_WIDTH-2:0]          w_lbuf_addr;

  assign w_pool_cfg_ok = !bus.cfg_row_width[0]
                      && (bus.cfg_row_width >= (ADDR_WIDTH+1)'(2))
                      && (bus.cfg_row_width <= W_MAX)
                      && !bus.cfg_num_rows[0]
                      && (bus.cfg_num_rows >= ROW_CNT_WIDTH'(2));
  assign w_byp_cfg_ok  = (bus.cfg_row_width >= (ADDR_WIDTH+1)'(1))
                      && (bus.cfg_row_width <= W_MAX)
                      && (bus.cfg_num_rows >= ROW_CNT_WIDTH'(1));
  assign w_cfg_ok      = bus.cfg_pool_enable ? w_pool_cfg_ok : w_byp_cfg_ok;

  // A start in the same cycle as in_valid wins: the sample is dropped.
  assign w_accept    = (r_state == S_RUN) && bus.in_valid && !bus.start;
  assign w_last_col  = (r_col == r_width - (ADDR_WIDTH+1)'(1));
  assign w_last_row  = (r_row == r_rows - ROW_CNT_WIDTH'(1));
  assign w_frame_end = w_accept && w_last_col && w_last_row;

  assign w_in_data   = $signed(bus.in_data);
  assign w_pair_max  = (r_hold > w_in_data) ? r_hold : w_in_data;
  assign w_lbuf_addr = r_col[ADDR_WIDTH-1:1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_emit       = 1'b0;
    w_emit_data  = '0;
    w_lbuf_we    = 1'b0;
    w_lbuf_re    = 1'b0;
    case (r_state)
      S_IDLE: if (bus.start && w_cfg_ok) w_state_next = S_RUN;
      S_RUN: begin
        if (bus.start)        w_state_next = w_cfg_ok ? S_RUN : S_IDLE;
        else if (w_frame_end) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
    if (w_accept) begin
      if (!r_pool) begin
        w_emit      = 1'b1;
        w_emit_data = w_in_data;
      end else if (!r_col[0]) begin
        // Prefetch the partner entry so it is registered by the odd column.
        w_lbuf_re = r_row[0];
      end else if (!r_row[0]) begin
        w_lbuf_we = 1'b1;
      end else begin
        w_emit      = 1'b1;
        w_emit_data = (r_lbuf_q > w_pair_max) ? r_lbuf_q : w_pair_max;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pool      <= 1'b0;
      r_width     <= '0;
      r_rows      <= '0;
      r_col       <= '0;
      r_row       <= '0;
      r_hold      <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_done      <= 1'b0;
      r_cfg_error <= 1'b0;
    end else begin
      r_out_valid <= w_emit;
      r_out_last  <= w_emit && w_frame_end;
      r_done      <= w_frame_end;
      if (w_emit) r_out_data <= w_emit_data;
      if (bus.start) begin
        r_cfg_error <= !w_cfg_ok;
        if (w_cfg_ok) begin
          r_pool  <= bus.cfg_pool_enable;
          r_width <= bus.cfg_row_width;
          r_rows  <= bus.cfg_num_rows;
          r_col   <= '0;
          r_row   <= '0;
        end
      end else if (w_accept) begin
        if (!r_col[0]) r_hold <= w_in_data;
        if (w_last_col) begin
          r_col <= '0;
          r_row <= r_row + ROW_CNT_WIDTH'(1);
        end else begin
          r_col <= r_col + (ADDR_WIDTH+1)'(1);
        end
      end
    end
  end

  // Line buffer: no reset so it maps onto block RAM; every entry is
  // rewritten on an even row before the odd row reads it.
  always_ff @(posedge clk) begin
    if (w_lbuf_we) r_lbuf[w_lbuf_addr] <= w_pair_max;
    if (w_lbuf_re) r_lbuf_q <= r_lbuf[w_lbuf_addr];
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_last  = r_out_last;
  assign bus.done      = r_done;
  // Held through the done cycle so busy falls the cycle after done.
  assign bus.busy      = (r_state == S_RUN) || r_done;
  assign bus.cfg_error = r_cfg_error;
endmodule

// File: tb/tb_pe_pool_2x2.sv
// Self-checking bench for pe_pool_2x2: frame-level reference model plus a
// per-cycle compare process, with literal expectations from the test plan.
module tb_pe_pool_2x2;
  localparam int OPW = 16;
  localparam int AW  = 8;
  localparam int RCW = 10;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pe_pool_2x2_if #(.OP_WIDTH(OPW), .ADDR_WIDTH(AW), .ROW_CNT_WIDTH(RCW)) bus();

  pe_pool_2x2 #(.OP_WIDTH(OPW), .ADDR_WIDTH(AW), .ROW_CNT_WIDTH(RCW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    int val;
    bit last;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t cmp_e;
  int   obs[$];
  int   data_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  bit   chk_en   = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int want);
    checks++;
    if (act != want) begin
      failures++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  // Outputs are sampled on the falling edge, half a cycle after they change.
  always @(negedge clk) begin
    if (chk_en) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        cmp_e = exp_q.pop_front();
        checks++; failures++;
        $display("FAIL out_missing: got nothing at cycle %0d, required %0d", cmp_e.cyc, cmp_e.val);
      end
      if (bus.out_valid) begin
        obs.push_back(int'($signed(bus.out_data)));
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
          cmp_e = exp_q.pop_front();
          $display("OUT cyc=%0d data=%0d want=%0d last=%0b", cyc, $signed(bus.out_data), cmp_e.val, bus.out_last);
          chk("out_data", int'($signed(bus.out_data)), cmp_e.val);
          chk("out_last", int'(bus.out_last), int'(cmp_e.last));
          chk("done_with_last", int'(bus.done), int'(cmp_e.last));
        end else begin
          checks++; failures++;
          $display("FAIL out_unexpected: got %0d at cycle %0d, required no output", $signed(bus.out_data), cyc);
        end
      end else begin
        chk("done_without_output", int'(bus.done), 0);
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
          cmp_e = exp_q.pop_front();
          checks++; failures++;
          $display("FAIL out_missing: got nothing at cycle %0d, required %0d", cyc, cmp_e.val);
        end
      end
    end
  end

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.start    = 1'b0;
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic do_start(input bit pool, input int w, input int rows, input bit ok,
                          input bit iv = 1'b0, input int ivd = 0);
    @(negedge clk);
    bus.start           = 1'b1;
    bus.cfg_pool_enable = pool;
    bus.cfg_row_width   = (AW+1)'(w);
    bus.cfg_num_rows    = RCW'(rows);
    bus.in_valid        = iv;
    bus.in_data         = OPW'(ivd);
    @(negedge clk);
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    $display("START pool=%0b w=%0d rows=%0d busy=%0b cfg_error=%0b", pool, w, rows, bus.busy, bus.cfg_error);
    chk("busy_after_start", int'(bus.busy), int'(ok));
    chk("cfg_error_after_start", int'(bus.cfg_error), int'(!ok));
  endtask

  task automatic send(input int d, input bit emit, input int v, input bit last);
    @(negedge clk);
    bus.start    = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = OPW'(d);
    if (emit) exp_q.push_back(exp_t'{v, last, cyc + 1});
  endtask

  // Reference: each 2x2 window's max is due once its bottom-right sample is in.
  task automatic run_frame(input bit pool, input int w, input int rows,
                           input int gmin, input int gmax, input int nsend = -1);
    int n = w * rows;
    int lim = (nsend < 0) ? n : nsend;
    for (int i = 0; i < lim; i++) begin
      int r = i / w;
      int c = i % w;
      bit emit = 1'b0;
      int v = 0;
      if (!pool) begin
        emit = 1'b1;
        v    = data_q[i];
      end else if ((r % 2 == 1) && (c % 2 == 1)) begin
        emit = 1'b1;
        v    = max2(max2(data_q[i-w-1], data_q[i-w]), max2(data_q[i-1], data_q[i]));
      end
      send(data_q[i], emit, v, i == n - 1);
      if (i != lim - 1) idle($urandom_range(gmax, gmin));
    end
    idle(1);
  endtask

  task automatic fill_random(input int n);
    data_q.delete();
    for (int i = 0; i < n; i++) data_q.push_back(int'($urandom_range(65535, 0)) - 32768);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    bus.start = 1'b0; bus.cfg_pool_enable = 1'b0; bus.cfg_row_width = '0;
    bus.cfg_num_rows = '0; bus.in_valid = 1'b0; bus.in_data = '0;

    @(negedge clk);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_data", int'(bus.out_data), 0);
    chk("rst_out_last", int'(bus.out_last), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_cfg_error", int'(bus.cfg_error), 0);
    idle(2);
    reset = 1'b0;
    idle(1);
    chk_en = 1'b1;

    // Pool 4x2 from the plan
    do_start(1'b1, 4, 2, 1'b1);
    data_q = '{1, 5, 2, 3, 4, 0, 7, -1};
    n0 = obs.size();
    run_frame(1'b1, 4, 2, 0, 0);
    chk("p1_done_pulse", int'(bus.done), 1);
    chk("p1_busy_in_done", int'(bus.busy), 1);
    idle(1);
    chk("p1_busy_drop", int'(bus.busy), 0);
    chk("p1_count", obs.size() - n0, 2);
    if (obs.size() >= n0 + 2) begin
      chk("p1_first", obs[n0], 5);
      chk("p1_second", obs[n0+1], 7);
    end

    // Negatives
    do_start(1'b1, 2, 2, 1'b1);
    data_q = '{-8, -3, -5, -9};
    n0 = obs.size();
    run_frame(1'b1, 2, 2, 0, 1);
    idle(2);
    chk("neg_count", obs.size() - n0, 1);
    if (obs.size() >= n0 + 1) chk("neg_value", obs[n0], -3);

    // Bypass with 2-cycle gaps
    do_start(1'b0, 3, 1, 1'b1);
    data_q = '{10, 20, 30};
    n0 = obs.size();
    run_frame(1'b0, 3, 1, 2, 2);
    idle(2);
    chk("byp_count", obs.size() - n0, 3);
    if (obs.size() >= n0 + 3) begin
      chk("byp_0", obs[n0], 10);
      chk("byp_1", obs[n0+1], 20);
      chk("byp_2", obs[n0+2], 30);
    end

    // Rejected configurations, then inputs that must be ignored
    do_start(1'b1, 3, 2, 1'b0);
    do_start(1'b1, 4, 3, 1'b0);
    do_start(1'b1, 0, 2, 1'b0);
    do_start(1'b1, 258, 2, 1'b0);
    do_start(1'b1, 4, 0, 1'b0);
    do_start(1'b0, 257, 1, 1'b0);
    do_start(1'b0, 0, 1, 1'b0);
    do_start(1'b0, 3, 0, 1'b0);
    n0 = obs.size();
    for (int i = 0; i < 4; i++) send(i * 7, 1'b0, 0, 1'b0);
    idle(3);
    chk("err_no_output", obs.size() - n0, 0);
    chk("err_busy_low", int'(bus.busy), 0);

    // Valid start clears the error; abort after 3 samples with a restart
    do_start(1'b1, 4, 2, 1'b1);
    for (int i = 0; i < 3; i++) send(1000 + i, 1'b0, 0, 1'b0);
    fill_random(8);
    n0 = obs.size();
    do_start(1'b1, 4, 2, 1'b1, 1'b1, 32000);
    run_frame(1'b1, 4, 2, 0, 1);
    idle(2);
    chk("abort_count", obs.size() - n0, 2);

    // Random small frames, both modes
    for (int k = 0; k < 8; k++) begin
      bit pool = 1'(($urandom_range(1, 0)));
      int w    = pool ? 2 * int'($urandom_range(8, 1)) : int'($urandom_range(10, 1));
      int rows = pool ? 2 * int'($urandom_range(3, 1)) : int'($urandom_range(4, 1));
      do_start(pool, w, rows, 1'b1);
      fill_random(w * rows);
      run_frame(pool, w, rows, 0, 2);
      idle(2);
      chk("rand_busy_idle", int'(bus.busy), 0);
    end

    // Max width, 4 rows
    do_start(1'b1, 256, 4, 1'b1);
    fill_random(1024);
    n0 = obs.size();
    run_frame(1'b1, 256, 4, 0, 1);
    idle(2);
    chk("maxw_count", obs.size() - n0, 256);

    // Second pass with reset asserted mid-frame while an output is showing
    do_start(1'b1, 256, 4, 1'b1);
    fill_random(1024);
    run_frame(1'b1, 256, 4, 0, 0, 302);
    chk("pre_reset_out_valid", int'(bus.out_valid), 1);
    #1;
    chk_en = 1'b0;
    exp_q.delete();
    reset = 1'b1;
    #1;
    chk("mid_rst_out_valid", int'(bus.out_valid), 0);
    chk("mid_rst_out_data", int'(bus.out_data), 0);
    chk("mid_rst_out_last", int'(bus.out_last), 0);
    chk("mid_rst_busy", int'(bus.busy), 0);
    chk("mid_rst_done", int'(bus.done), 0);
    idle(2);
    reset = 1'b0;
    idle(1);
    chk_en = 1'b1;
    idle(2);
    chk("post_rst_busy", int'(bus.busy), 0);

    // Frame after reset still pools correctly
    do_start(1'b1, 4, 2, 1'b1);
    fill_random(8);
    run_frame(1'b1, 4, 2, 0, 1);
    idle(3);
    chk("leftover_expected", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
